// File: rtl/button_debounce_pio.sv
// Avalon-MM input PIO for active-low push-buttons: 2-flop sync, per-bit debounce,
// sticky edge capture and maskable irq. Define BUTTON_PIO_BOTH_EDGES_EN to capture release edges too.
module button_debounce_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0]            stable_dly_q, stable_dly_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            irqmask_q, irqmask_d;
  logic [WIDTH-1:0]            edgecap_q, edgecap_d;
  logic [31:0]                 readdata_q, readdata_d;
  logic                        irq_q, irq_d;

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] ec_clr;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & write_n;
  assign unused_wdata = ^writedata;

`ifdef BUTTON_PIO_BOTH_EDGES_EN
  assign edge_set = stable_dly_q ^ stable_q;
`else
  assign edge_set = stable_dly_q & ~stable_q;
`endif

  assign ec_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    sync1_d      = in_port;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = cnt_q;
    // A bit's counter only runs while the synced level disagrees with the accepted one.
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    // Set dominates clear so a press coinciding with a W1C is not lost.
    edgecap_d = (edgecap_q & ~ec_clr) | edge_set;
    irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
    irq_d     = |(edgecap_q & irqmask_q);

    readdata_d = 32'd0;
    if (rd_en) begin
      case (address)
        2'd0:    readdata_d = 32'(stable_q);
        2'd2:    readdata_d = 32'(irqmask_q);
        2'd3:    readdata_d = 32'(edgecap_q);
        default: readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      stable_q     <= '1;
      stable_dly_q <= '1;
      cnt_q        <= '0;
      irqmask_q    <= '0;
      edgecap_q    <= '0;
      readdata_q   <= 32'd0;
      irq_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      irqmask_q    <= irqmask_d;
      edgecap_q    <= edgecap_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_button_debounce_pio.sv
// Bench for button_debounce_pio with a short debounce window; history-window reference model.
module tb_button_debounce_pio;

  localparam int W = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  in_port = '1;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic          irq;

  int total = 0;
  int bad = 0;

  // Reference state: value of each observable after the most recent edge.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_prev, m_ec, m_mask;
  logic         m_irq;
  logic [31:0]  m_rd;

  button_debounce_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .in_port(in_port), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A level is accepted once the synchronised input (pins delayed two edges)
  // has shown the opposite level for the last D edges in a row.
  task automatic model_edge();
    int e;
    int idx;
    logic [W-1:0] smp;
    logic [W-1:0] nstable;
    logic [W-1:0] setv;
    logic [W-1:0] clrv;
    logic         all_diff;
    e = hist.size();
    hist.push_back(in_port);
    nstable = m_stable;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int i = 0; i < D; i++) begin
        idx = e - 2 - i;
        smp = (idx >= 0) ? hist[idx] : '1;
        if (smp[b] == m_stable[b]) all_diff = 1'b0;
      end
      if (all_diff) nstable[b] = ~m_stable[b];
    end
`ifdef BUTTON_PIO_BOTH_EDGES_EN
    setv = m_prev ^ m_stable;
`else
    setv = m_prev & ~m_stable;
`endif
    clrv = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    m_rd = 32'd0;
    if (chipselect && write_n) begin
      if (address == 2'd0) m_rd = {28'd0, m_stable};
      else if (address == 2'd2) m_rd = {28'd0, m_mask};
      else if (address == 2'd3) m_rd = {28'd0, m_ec};
    end
    m_irq = (m_ec & m_mask) != 0;
    m_ec  = (m_ec & ~clrv) | setv;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_prev   = m_stable;
    m_stable = nstable;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_rd", readdata, m_rd);
    check("model_irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hist.delete();
    m_stable = '1; m_prev = '1; m_ec = '0; m_mask = '0; m_irq = 1'b0; m_rd = 32'd0;
    @(posedge clk);
    #1;
    check("reset_rd", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    tick();
    chipselect = 1'b0;
    check(tag, readdata, exp);
  endtask

  initial begin
    logic [W-1:0] pins;
    int r;

    do_reset();
    ticks(2);
    bus_read("rst_data", 2'd0, 32'h0000000F);
    bus_read("rst_mask", 2'd2, 32'h00000000);
    bus_read("rst_ec", 2'd3, 32'h00000000);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Glitch one cycle shorter than the window is rejected.
    in_port = 4'hE;
    ticks(3);
    in_port = 4'hF;
    ticks(10);
    bus_read("glitch_data", 2'd0, 32'h0000000F);
    bus_read("glitch_ec", 2'd3, 32'h00000000);

    // Held press is accepted on the D+2'th edge; read pipeline shows it one edge later.
    in_port = 4'hD;
    chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
    ticks(6);
    check("lat_before", readdata, 32'h0000000F);
    tick();
    check("lat_after", readdata, 32'h0000000D);
    chipselect = 1'b0;
    bus_read("press_ec", 2'd3, 32'h00000002);
    check("press_irq_masked", {31'd0, irq}, 32'd0);

    bus_write(2'd2, 32'h00000002);
    check("mask_irq_early", {31'd0, irq}, 32'd0);
    tick();
    check("mask_irq", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h00000002);
    tick();
    check("w1c_irq", {31'd0, irq}, 32'd0);
    bus_read("w1c_ec", 2'd3, 32'h00000000);

    // Press on bit 2 lands in edgecapture on the same edge as a W1C of that bit.
    in_port = 4'h9;
    ticks(6);
    bus_write(2'd3, 32'h00000004);
    bus_read("set_wins", 2'd3, 32'h00000004);

    bus_write(2'd3, 32'h0000000F);
    in_port = 4'h1;
    ticks(10);
    bus_read("press3_ec", 2'd3, 32'h00000008);
    bus_write(2'd3, 32'h0000000F);
    in_port = 4'h9;
    ticks(10);
`ifdef BUTTON_PIO_BOTH_EDGES_EN
    bus_read("release3_ec", 2'd3, 32'h00000008);
`else
    bus_read("release3_ec", 2'd3, 32'h00000000);
`endif

    bus_write(2'd0, 32'h00000000);
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_read("ro_data", 2'd0, 32'h00000009);
    bus_read("rsvd", 2'd1, 32'h00000000);
    bus_read("mask_rd", 2'd2, 32'h00000002);

    // Reset in the middle of a debounce discards the partial count.
    in_port = 4'h8;
    ticks(3);
    do_reset();
    chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
    ticks(6);
    check("rstmid_before", readdata, 32'h0000000F);
    tick();
    check("rstmid_after", readdata, 32'h00000008);
    chipselect = 1'b0;
    ticks(2);
    bus_read("rstmid_ec", 2'd3, 32'h00000007);

    // Random pins and bus traffic against the model.
    for (int c = 0; c < 600; c++) begin
      pins = in_port;
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) pins[b] = ~pins[b];
      in_port = pins;
      r = $urandom_range(0, 9);
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
      if (r >= 4 && r <= 6) begin
        chipselect = 1'b1; address = 2'($urandom_range(0, 3));
      end else if (r >= 7) begin
        chipselect = 1'b1; write_n = 1'b0;
        address = (r == 9) ? 2'($urandom_range(0, 3)) : 2'd3;
        writedata = $urandom;
      end
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    ticks(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
